// File: rtl/monitor_multicanal.sv
// monitor_multicanal
// Multi-channel position monitor. Each channel synchronises its raw position
// input, debounces it, detects debounced rising edges and fires a gatilho pulse
// of PULSE_W cycles followed by a HOLDOFF-cycle hold-off before re-arming.
// A combined trigger and a saturating count of fired pulses are also provided.

module monitor_multicanal #(
   parameter int N_CH     = 4,
   parameter int DEBOUNCE = 4,
   parameter int PULSE_W  = 2,
   parameter int HOLDOFF  = 8,
   parameter int COUNT_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_CH-1:0]    enable,
   input  logic [N_CH-1:0]    position,
   input  logic               clear_count,
   output logic [N_CH-1:0]    gatilho,
   output logic               gatilho_any,
   output logic [N_CH-1:0]    armed,
   output logic [COUNT_W-1:0] trig_count
);

   localparam int DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int PCNT_W = $clog2(PULSE_W + 1);
   localparam int HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int INC_W  = $clog2(N_CH + 1);
   localparam int SUM_W  = COUNT_W + INC_W;
   localparam logic [SUM_W-1:0] CNT_MAX = {{INC_W{1'b0}}, {COUNT_W{1'b1}}};

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      IDLE     = 2'd1,
      FIRE     = 2'd2,
      HOLD     = 2'd3
   } state_t;

   logic [N_CH-1:0]    fire_vec;
   logic [N_CH-1:0]    gat_next_vec;
   logic [INC_W-1:0]   fire_pop;
   logic [SUM_W-1:0]   count_sum;
   logic [COUNT_W-1:0] count_next;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic              sync1;
      logic              pos_s;
      logic              deb_lvl;
      logic              deb_prev;
      logic [DEB_W-1:0]  deb_cnt;
      logic [PCNT_W-1:0] pcnt;
      logic [HCNT_W-1:0] hcnt;
      logic              gat_r;
      logic              armed_r;
      logic              rise;
      logic              pulse_last;
      logic              fire_start;
      logic              gat_next;
      state_t            state;

      // Two-flop synchroniser bringing the asynchronous position into the clock domain
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            sync1 <= 1'b0;
            pos_s <= 1'b0;
         end else begin
            sync1 <= position[i];
            pos_s <= sync1;
         end
      end

      // Debounce: accept a new level only after DEBOUNCE consecutive differing samples
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            deb_lvl  <= 1'b0;
            deb_prev <= 1'b0;
            deb_cnt  <= '0;
         end else begin
            deb_prev <= deb_lvl;
            if (pos_s != deb_lvl) begin
               if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                  deb_lvl <= pos_s;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end else begin
               deb_cnt <= '0;
            end
         end
      end

      assign rise       = deb_lvl & ~deb_prev;
      assign pulse_last = (pcnt == PCNT_W'(PULSE_W - 1));
      assign fire_start = (state == IDLE) && enable[i] && rise;
      assign gat_next   = enable[i] && (fire_start || ((state == FIRE) && !pulse_last));

      // Channel FSM: arm, fire a fixed-width pulse, hold off, re-arm; enable low always disarms
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            state   <= DISARMED;
            pcnt    <= '0;
            hcnt    <= '0;
            gat_r   <= 1'b0;
            armed_r <= 1'b0;
         end else begin
            gat_r   <= gat_next;
            armed_r <= 1'b0;
            if (!enable[i]) begin
               state <= DISARMED;
            end else begin
               case (state)
                  DISARMED: begin
                     state   <= IDLE;
                     armed_r <= 1'b1;
                  end
                  IDLE: begin
                     if (rise) begin
                        state <= FIRE;
                        pcnt  <= '0;
                     end else begin
                        armed_r <= 1'b1;
                     end
                  end
                  FIRE: begin
                     if (pulse_last) begin
                        if (HOLDOFF == 0) begin
                           state   <= IDLE;
                           armed_r <= 1'b1;
                        end else begin
                           state <= HOLD;
                           hcnt  <= '0;
                        end
                     end else begin
                        pcnt <= pcnt + 1'b1;
                     end
                  end
                  HOLD: begin
                     if (hcnt == HCNT_W'(HOLDOFF - 1)) begin
                        state   <= IDLE;
                        armed_r <= 1'b1;
                     end else begin
                        hcnt <= hcnt + 1'b1;
                     end
                  end
                  default: begin
                     state <= DISARMED;
                  end
               endcase
            end
         end
      end

      assign fire_vec[i]     = fire_start;
      assign gat_next_vec[i] = gat_next;
      assign gatilho[i]      = gat_r;
      assign armed[i]        = armed_r;
   end

   // Number of channels starting a pulse this cycle, added to the count with saturation
   always_comb begin
      fire_pop = '0;
      for (int k = 0; k < N_CH; k++) begin
         fire_pop = fire_pop + INC_W'(fire_vec[k]);
      end
      count_sum  = SUM_W'(trig_count) + SUM_W'(fire_pop);
      count_next = (count_sum > CNT_MAX) ? {COUNT_W{1'b1}} : count_sum[COUNT_W-1:0];
   end

   // Saturating trigger counter; a clear wins over pulses fired on the same edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trig_count <= '0;
      end else if (clear_count) begin
         trig_count <= '0;
      end else begin
         trig_count <= count_next;
      end
   end

   // Combined trigger registered from the same next values as the per-channel pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gatilho_any <= 1'b0;
      end else begin
         gatilho_any <= |gat_next_vec;
      end
   end

endmodule
